clken_stream_bridge: RTL and testbench

Byte-stream bridge between logic running every `sys_clock` cycle, such as a keyboard decoder or serial receiver, and devices that advance only on `cpu_clken`. The producer pushes bytes at full `sys_clock` rate through a ready/valid handshake into a small FIFO. The bridge presents one byte at a time to the slow side and changes that byte only on `cpu_clken` cycles, so a CPU-side device sees data that is stable for a whole CPU cycle. It consumes the enable that the system clock divider produces and sits between fast input front-ends and the PIA/peripheral logic.

---
 rtl/clken_stream_bridge_if.sv | 26 ++
 rtl/clken_stream_bridge.sv | 121 ++++++++++++
 tb/tb_clken_stream_bridge.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clken_stream_bridge_if.sv
// Signal bundle between a full-rate byte producer, the bridge, and a cpu_clken-gated consumer.
// The master side drives the producer and consumer controls; the slave side is the bridge.
interface clken_stream_bridge_if #(
  parameter int AW = 2
);
  logic          cpu_clken;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ack;
  logic          overflow;
  logic          ovf_clear;
  logic [AW:0]   level;

  modport master (
    output cpu_clken, in_data, in_valid, out_ack, ovf_clear,
    input  in_ready, out_data, out_valid, overflow, level
  );

  modport slave (
    input  cpu_clken, in_data, in_valid, out_ack, ovf_clear,
    output in_ready, out_data, out_valid, overflow, level
  );
endinterface

// File: rtl/clken_stream_bridge.sv
// Byte FIFO from a full-rate producer to an output register that only changes on cpu_clken edges.
// Bytes offered while the FIFO is full are dropped and latch the sticky overflow flag.
module clken_stream_bridge #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                 sys_clock,
  input  logic                 reset,
  clken_stream_bridge_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [7:0]    r_out_data;
  logic          r_overflow;
  out_state_e    r_state;
  out_state_e    w_state_nxt;

  logic w_in_ready;
  logic w_push;
  logic w_refuse;
  logic w_fifo_nempty;
  logic w_pop;
  logic w_out_valid;

  // Ready comes from registered occupancy only, so a same-cycle pop never frees a slot early.
  assign w_in_ready    = (r_level != L_DEPTH);
  assign w_push        = bus.in_valid && w_in_ready;
  assign w_refuse      = bus.in_valid && !w_in_ready;
  assign w_fifo_nempty = (r_level != '0);

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.cpu_clken) begin
      case (r_state)
        ST_EMPTY: if (w_fifo_nempty) w_state_nxt = ST_FULL;
        ST_FULL:  if (bus.out_ack && !w_fifo_nempty) w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // A FULL register with ack and a waiting byte reloads in place, giving a gapless handoff.
  always_comb begin
    w_out_valid = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        w_pop = bus.cpu_clken && w_fifo_nempty;
      end
      ST_FULL: begin
        w_out_valid = 1'b1;
        w_pop       = bus.cpu_clken && bus.out_ack && w_fifo_nempty;
      end
    endcase
  end

  always_ff @(posedge sys_clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Going EMPTY leaves the last byte visible on out_data.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_out_data <= 8'h00;
    end else if (w_pop) begin
      r_out_data <= r_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_refuse) begin
      r_overflow <= 1'b1;
    end else if (bus.ovf_clear) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = w_out_valid;
  assign bus.overflow  = r_overflow;
  assign bus.level     = r_level;

endmodule

// File: tb/tb_clken_stream_bridge.sv
// Bench for clken_stream_bridge: directed scenarios plus randomized traffic against a queue model.
module tb_clken_stream_bridge;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clken_stream_bridge_if #(.AW(AW)) b();

  clken_stream_bridge #(.DEPTH(DEPTH), .AW(AW)) dut (
    .sys_clock (clk),
    .reset     (rst),
    .bus       (b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int div_cnt = 0;
  bit en_rand = 1'b0;

  // Reference: a byte queue plus an output slot, updated from the inputs seen at each edge.
  logic [7:0] mq[$];
  bit         m_full = 1'b0;
  logic [7:0] m_data = 8'h00;
  bit         m_ovf  = 1'b0;
  int         m_push_cnt = 0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_full = 1'b0;
      m_data = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      bit acc;
      bit drop;
      acc  = b.in_valid && (mq.size() < DEPTH);
      drop = b.in_valid && (mq.size() >= DEPTH);
      if (b.cpu_clken && (!m_full || b.out_ack)) begin
        if (mq.size() > 0) begin
          m_data = mq.pop_front();
          m_full = 1'b1;
        end else begin
          m_full = 1'b0;
        end
      end
      if (acc) begin
        mq.push_back(b.in_data);
        m_push_cnt++;
      end
      if (drop) m_ovf = 1'b1;
      else if (b.ovf_clear) m_ovf = 1'b0;
    end
  end

  // One clock: outputs of the edge are stable on return; cpu_clken is set up for the next edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    div_cnt = (div_cnt == 6) ? 0 : div_cnt + 1;
    b.cpu_clken = en_rand ? ($urandom_range(0, 2) == 0) : (div_cnt == 6);
  endtask

  task automatic to_enable(output int n);
    bit en;
    n = 0;
    do begin
      en = b.cpu_clken;
      tick();
      n++;
    end while (!en && n < 40);
    if (!en) begin
      n = -1;
      n_tests++; n_fail++;
      $display("FAIL enable_timeout no cpu_clken edge within 40 cycles");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    b.in_valid = 1'b0; b.out_ack = 1'b0; b.ovf_clear = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b.in_valid = 1'b1; b.in_data = 8'hEE; b.out_ack = 1'b1; b.ovf_clear = 1'b0;
    tick();
    rst = 1'b0; b.in_valid = 1'b0; b.out_ack = 1'b0;
    n_tests++; if (b.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", b.in_ready); end
    n_tests++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", b.out_valid); end
    n_tests++; if (b.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", b.out_data); end
    n_tests++; if (b.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got %b want 0", b.overflow); end
    n_tests++; if (b.level !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", b.level); end
  endtask

  task automatic test_single_byte();
    int n;
    do_reset();
    to_enable(n);
    tick();
    b.in_valid = 1'b1; b.in_data = 8'h41;
    tick();
    b.in_valid = 1'b0;
    n_tests++; if (b.level !== 3'd1) begin n_fail++; $display("FAIL single_level_after_push got %0d want 1", b.level); end
    n_tests++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid got %b want 0", b.out_valid); end
    to_enable(n);
    n_tests++; if (n != 5) begin n_fail++; $display("FAIL single_latency got %0d want 5 cycles", n); end
    n_tests++; if (b.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %b want 1", b.out_valid); end
    n_tests++; if (b.out_data !== 8'h41) begin n_fail++; $display("FAIL single_data got %h want 41", b.out_data); end
    b.out_ack = 1'b1;
    to_enable(n);
    b.out_ack = 1'b0;
    n_tests++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_ack_valid got %b want 0", b.out_valid); end
    n_tests++; if (b.level !== 3'd0) begin n_fail++; $display("FAIL single_ack_level got %0d want 0", b.level); end
    n_tests++; if (b.out_data !== 8'h41) begin n_fail++; $display("FAIL single_hold_data got %h want 41", b.out_data); end
  endtask

  task automatic test_fill_overflow();
    int n;
    do_reset();
    b.in_valid = 1'b1; b.in_data = 8'h01;
    tick();
    b.in_valid = 1'b0;
    to_enable(n);
    n_tests++; if (b.out_data !== 8'h01 || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL fill_first got v=%b d=%h want v=1 d=01", b.out_valid, b.out_data); end
    for (int i = 2; i <= 6; i++) begin
      b.in_valid = 1'b1; b.in_data = 8'(i);
      tick();
      if (i == 5) begin
        n_tests++; if (b.level !== 3'd4) begin n_fail++; $display("FAIL fill_level got %0d want 4", b.level); end
        n_tests++; if (b.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready got %b want 0", b.in_ready); end
        n_tests++; if (b.overflow !== 1'b0) begin n_fail++; $display("FAIL fill_early_ovf got %b want 0", b.overflow); end
      end
    end
    b.in_valid = 1'b0;
    n_tests++; if (b.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", b.overflow); end
    n_tests++; if (b.level !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", b.level); end
    b.ovf_clear = 1'b1;
    tick();
    b.ovf_clear = 1'b0;
    n_tests++; if (b.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0", b.overflow); end
    b.in_valid = 1'b1; b.in_data = 8'h77; b.ovf_clear = 1'b1;
    tick();
    b.in_valid = 1'b0; b.ovf_clear = 1'b0;
    n_tests++; if (b.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set_wins got %b want 1", b.overflow); end
    b.ovf_clear = 1'b1;
    tick();
    b.ovf_clear = 1'b0;
    b.out_ack = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      to_enable(n);
      n_tests++; if (b.out_data !== 8'(k) || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_byte got v=%b d=%h want v=1 d=%h", b.out_valid, b.out_data, 8'(k)); end
    end
    to_enable(n);
    b.out_ack = 1'b0;
    n_tests++; if (b.out_valid !== 1'b0 || b.level !== 3'd0) begin n_fail++; $display("FAIL drain_end got v=%b lvl=%0d want v=0 lvl=0", b.out_valid, b.level); end
  endtask

  task automatic test_streaming();
    int sent, got;
    bit done;
    logic [7:0] prev;
    do_reset();
    b.out_ack = 1'b1;
    sent = 0; got = 0; done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      bit en, pushing;
      pushing = (sent < 16) && b.in_ready;
      b.in_valid = pushing;
      b.in_data = 8'h10 + 8'(sent);
      en = b.cpu_clken;
      prev = b.out_data;
      tick();
      if (pushing) sent++;
      if (!en) begin
        n_tests++; if (b.out_data !== prev) begin n_fail++; $display("FAIL stream_data_off_enable got %h want %h", b.out_data, prev); end
      end else if (b.out_valid) begin
        n_tests++; if (b.out_data !== 8'h10 + 8'(got)) begin n_fail++; $display("FAIL stream_order got %h want %h", b.out_data, 8'h10 + 8'(got)); end
        got++;
      end else if (got > 0 && got < 16) begin
        n_tests++; n_fail++; $display("FAIL stream_gap out_valid 0 after %0d bytes want 1", got);
      end else if (got >= 16) begin
        done = 1'b1;
      end
    end
    b.in_valid = 1'b0; b.out_ack = 1'b0;
    n_tests++; if (!done || got != 16) begin n_fail++; $display("FAIL stream_count got %0d bytes want 16", got); end
  endtask

  task automatic test_ack_gating();
    int n;
    do_reset();
    b.in_valid = 1'b1; b.in_data = 8'hA5;
    tick();
    b.in_data = 8'hB6;
    tick();
    b.in_valid = 1'b0;
    to_enable(n);
    n_tests++; if (b.out_data !== 8'hA5 || b.level !== 3'd1) begin n_fail++; $display("FAIL gate_setup got d=%h lvl=%0d want d=a5 lvl=1", b.out_data, b.level); end
    for (int c = 0; c < 21; c++) begin
      b.out_ack = !b.cpu_clken;
      tick();
      n_tests++; if (b.out_data !== 8'hA5 || b.out_valid !== 1'b1) begin n_fail++; $display("FAIL gate_data got v=%b d=%h want v=1 d=a5", b.out_valid, b.out_data); end
      n_tests++; if (b.level !== 3'd1) begin n_fail++; $display("FAIL gate_level got %0d want 1", b.level); end
    end
    b.out_ack = 1'b0;
  endtask

  task automatic test_wrap_random();
    do_reset();
    en_rand = 1'b1;
    for (int r = 0; r < 3; r++) begin
      int start;
      bit drained;
      start = m_push_cnt;
      for (int c = 0; c < 2000 && (m_push_cnt - start) < 3 * DEPTH; c++) begin
        b.in_valid  = ($urandom_range(0, 3) > r);
        b.in_data   = 8'($urandom);
        b.out_ack   = ($urandom_range(0, 3) != 0);
        b.ovf_clear = ($urandom_range(0, 7) == 0);
        tick();
        n_tests++; if (b.out_valid !== m_full) begin n_fail++; $display("FAIL rand_out_valid got %b want %b", b.out_valid, m_full); end
        n_tests++; if (b.out_data !== m_data) begin n_fail++; $display("FAIL rand_out_data got %h want %h", b.out_data, m_data); end
        n_tests++; if (b.level !== 3'(mq.size()) || b.level > 3'(DEPTH)) begin n_fail++; $display("FAIL rand_level got %0d want %0d", b.level, mq.size()); end
        n_tests++; if (b.in_ready !== (mq.size() != DEPTH)) begin n_fail++; $display("FAIL rand_in_ready got %b want %b", b.in_ready, mq.size() != DEPTH); end
        n_tests++; if (b.overflow !== m_ovf) begin n_fail++; $display("FAIL rand_overflow got %b want %b", b.overflow, m_ovf); end
      end
      n_tests++; if ((m_push_cnt - start) < 3 * DEPTH) begin n_fail++; $display("FAIL rand_push_budget got %0d pushes want %0d", m_push_cnt - start, 3 * DEPTH); end
      b.in_valid = 1'b0; b.out_ack = 1'b1; b.ovf_clear = 1'b0;
      drained = 1'b0;
      for (int c = 0; c < 300 && !drained; c++) begin
        tick();
        n_tests++; if (b.out_data !== m_data || b.out_valid !== m_full) begin n_fail++; $display("FAIL drain_rand got v=%b d=%h want v=%b d=%h", b.out_valid, b.out_data, m_full, m_data); end
        drained = (mq.size() == 0) && !m_full;
      end
      n_tests++; if (!drained || b.level !== 3'd0 || b.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_rand_end got v=%b lvl=%0d want v=0 lvl=0", b.out_valid, b.level); end
      b.out_ack = 1'b0;
    end
    en_rand = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    b.in_valid = 1'b1; b.in_data = 8'h60;
    tick();
    b.in_valid = 1'b0;
    to_enable(n);
    for (int i = 1; i <= 5; i++) begin
      b.in_valid = 1'b1; b.in_data = 8'h60 + 8'(i);
      tick();
    end
    b.in_valid = 1'b0; b.out_ack = 1'b1;
    to_enable(n);
    b.out_ack = 1'b0;
    n_tests++; if (b.level !== 3'd3 || b.out_valid !== 1'b1 || b.overflow !== 1'b1) begin n_fail++; $display("FAIL mid_setup got lvl=%0d v=%b ovf=%b want lvl=3 v=1 ovf=1", b.level, b.out_valid, b.overflow); end
    n_tests++; if (b.out_data !== 8'h61) begin n_fail++; $display("FAIL mid_setup_data got %h want 61", b.out_data); end
    rst = 1'b1; b.in_valid = 1'b1; b.in_data = 8'h99;
    tick();
    rst = 1'b0; b.in_valid = 1'b0;
    n_tests++; if (b.level !== 3'd0 || b.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_fifo got lvl=%0d rdy=%b want lvl=0 rdy=1", b.level, b.in_ready); end
    n_tests++; if (b.out_valid !== 1'b0 || b.out_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_out got v=%b d=%h want v=0 d=00", b.out_valid, b.out_data); end
    n_tests++; if (b.overflow !== 1'b0) begin n_fail++; $display("FAIL mid_reset_ovf got %b want 0", b.overflow); end
    to_enable(n);
    n_tests++; if (b.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale_present got %b want 0", b.out_valid); end
    b.in_valid = 1'b1; b.in_data = 8'h7E;
    tick();
    b.in_valid = 1'b0;
    to_enable(n);
    n_tests++; if (b.out_valid !== 1'b1 || b.out_data !== 8'h7E) begin n_fail++; $display("FAIL mid_first_after_reset got v=%b d=%h want v=1 d=7e", b.out_valid, b.out_data); end
  endtask

  initial begin
    rst = 1'b1;
    b.cpu_clken = 1'b0; b.in_valid = 1'b0; b.in_data = 8'h00;
    b.out_ack = 1'b0; b.ovf_clear = 1'b0;
    tick();
    tick();
    test_reset();
    test_single_byte();
    test_fill_overflow();
    test_streaming();
    test_ack_gating();
    test_wrap_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
